// File: rtl/opm_write_sequencer.sv
// Host-side write buffer for the IKAOPM core: queues {addr,data} pairs and replays
// each as phiM-aligned address/data strobes, then polls the OPM busy flag.
module opm_write_sequencer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int STROBE_PCEN = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       phim_pcen_n,
    input  logic       host_wr,
    input  logic       host_a0,
    input  logic [7:0] host_din,
    input  logic       host_rd_status,
    output logic [7:0] status_o,
    output logic       fifo_full_o,
    output logic       opm_cs_n,
    output logic       opm_wr_n,
    output logic       opm_rd_n,
    output logic       opm_a0,
    output logic [7:0] opm_d,
    input  logic [7:0] opm_q
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = $clog2(STROBE_PCEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [PW-1:0] PC_LAST  = PW'(STROBE_PCEN);
    localparam logic [PW-1:0] PC_ONE   = PW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_ONE = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR_WR  = 3'd1,
        S_ADDR_GAP = 3'd2,
        S_DATA_WR  = 3'd3,
        S_DATA_GAP = 3'd4,
        S_POLL     = 3'd5
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [15:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic [7:0]    r_hold_addr, r_ent_a, r_ent_d, r_d;
    logic [PW-1:0] r_pcnt;
    logic [TW-1:0] r_tcnt;
    logic          r_ovf, r_tmo, r_cs_n, r_wr_n, r_rd_n, r_a0;

    logic        w_pulse, w_empty, w_full, w_pop, w_push_req, w_push, w_ovf_set;
    logic        w_tmo_set, w_rearm, w_busy;
    logic        w_cs_n_nxt, w_wr_n_nxt, w_rd_n_nxt, w_a0_nxt;
    logic [7:0]  w_d_nxt;
    logic [15:0] w_head;

    assign w_pulse    = ~phim_pcen_n;
    assign w_empty    = (r_count == {(AW+1){1'b0}});
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;
    assign w_push_req = host_wr & host_a0;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_head     = r_mem[r_rptr];
    assign w_busy     = ~w_empty | (r_state != S_IDLE);

    assign status_o    = {w_busy, r_ovf, r_tmo, 3'b000, opm_q[1:0]};
    assign fifo_full_o = w_full;
    assign opm_cs_n    = r_cs_n;
    assign opm_wr_n    = r_wr_n;
    assign opm_rd_n    = r_rd_n;
    assign opm_a0      = r_a0;
    assign opm_d       = r_d;

    // Next-state decode plus next values for the registered bus outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_set   = 1'b0;
        w_rearm     = 1'b0;
        w_cs_n_nxt  = 1'b1;
        w_wr_n_nxt  = 1'b1;
        w_rd_n_nxt  = 1'b1;
        w_a0_nxt    = r_a0;
        w_d_nxt     = r_d;
        case (r_state)
            S_IDLE:     if (!w_empty) w_state_nxt = S_ADDR_WR; else w_state_nxt = S_IDLE;
            S_ADDR_WR:  if (r_pcnt == PC_LAST) w_state_nxt = S_ADDR_GAP; else w_state_nxt = S_ADDR_WR;
            S_ADDR_GAP: if (r_pcnt == PC_ONE) w_state_nxt = S_DATA_WR; else w_state_nxt = S_ADDR_GAP;
            S_DATA_WR:  if (r_pcnt == PC_LAST) w_state_nxt = S_DATA_GAP; else w_state_nxt = S_DATA_WR;
            S_DATA_GAP: if (r_pcnt == PC_ONE) w_state_nxt = S_POLL; else w_state_nxt = S_DATA_GAP;
            S_POLL: begin
                // A not-busy sample takes priority over a timeout in the same cycle.
                if ((r_pcnt == PC_LAST) && !opm_q[7]) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tcnt == TMO_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_tmo_set   = 1'b1;
                end else begin
                    w_state_nxt = S_POLL;
                    w_rearm     = (r_pcnt == PC_LAST);
                end
            end
            default:    w_state_nxt = S_IDLE;
        endcase
        case (w_state_nxt)
            S_ADDR_WR: begin w_cs_n_nxt = 1'b0; w_wr_n_nxt = 1'b0; w_a0_nxt = 1'b0; end
            S_DATA_WR: begin w_cs_n_nxt = 1'b0; w_wr_n_nxt = 1'b0; w_a0_nxt = 1'b1; end
            S_POLL:    begin w_cs_n_nxt = 1'b0; w_rd_n_nxt = 1'b0; w_a0_nxt = 1'b1; end
            default:   begin w_cs_n_nxt = 1'b1; w_wr_n_nxt = 1'b1; w_rd_n_nxt = 1'b1; end
        endcase
        if (w_pop) begin
            w_d_nxt = w_head[15:8];
        end else if ((w_state_nxt == S_DATA_WR) && (r_state != S_DATA_WR)) begin
            w_d_nxt = r_ent_d;
        end else begin
            w_d_nxt = r_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {r_hold_addr, host_din};
    end

    // FIFO pointers/count, holding address, sticky flags and popped entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr      <= {AW{1'b0}};
            r_rptr      <= {AW{1'b0}};
            r_count     <= {(AW+1){1'b0}};
            r_hold_addr <= 8'h00;
            r_ent_a     <= 8'h00;
            r_ent_d     <= 8'h00;
            r_ovf       <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
            if (host_wr && !host_a0) r_hold_addr <= host_din;
            if (w_pop) {r_ent_a, r_ent_d} <= w_head;
            if (w_ovf_set)           r_ovf <= 1'b1;
            else if (host_rd_status) r_ovf <= 1'b0;
            if (w_tmo_set)           r_tmo <= 1'b1;
            else if (host_rd_status) r_tmo <= 1'b0;
        end
    end

    // FSM state, per-state pulse counter, POLL cycle counter and bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pcnt  <= {PW{1'b0}};
            r_tcnt  <= {TW{1'b0}};
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_a0    <= 1'b0;
            r_d     <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || w_rearm) r_pcnt <= {PW{1'b0}};
            else if (w_pulse && (r_pcnt != PC_LAST)) r_pcnt <= r_pcnt + PC_ONE;
            if ((r_state == S_POLL) && (w_state_nxt == S_POLL)) r_tcnt <= r_tcnt + TCNT_ONE;
            else r_tcnt <= {TW{1'b0}};
            r_cs_n  <= w_cs_n_nxt;
            r_wr_n  <= w_wr_n_nxt;
            r_rd_n  <= w_rd_n_nxt;
            r_a0    <= w_a0_nxt;
            r_d     <= w_d_nxt;
        end
    end
endmodule
